// File: rtl/fsqrt_pkg.sv
// fsqrt_pkg: shared constants, state encoding and canonical-NaN helper for the iterative square-root unit.
package fsqrt_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RZ  = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int MAX_W = 128;

    typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} state_t;

    // Quiet NaN with all-ones exponent and only the top fraction bit set.
    function automatic logic [MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = man_w - 1; i < man_w + exp_w; i++) v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fsqrt_lzc.sv
// fsqrt_lzc: leading-zero count of a MAN_W-bit fraction; an all-zero input yields MAN_W.
module fsqrt_lzc #(
    parameter int MAN_W = 23,
    localparam int CW = $clog2(MAN_W + 1)
) (
    input  logic [MAN_W-1:0] frac,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = CW'(MAN_W);
        for (int i = 0; i < MAN_W; i++)
            if (frac[i]) count = CW'(MAN_W - 1 - i);
    end

endmodule

// File: rtl/fsqrt_iter.sv
// fsqrt_iter: radix-2 restoring IEEE-754 square root, one root bit per cycle behind a start/done handshake.
module fsqrt_iter
    import fsqrt_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   op,
    input  logic [2:0]             rm,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [4:0]             flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int Q_W  = MAN_W + 2;
    localparam int R_W  = Q_W + 2;
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int CW   = $clog2(MAN_W + 1);
    localparam int NW   = $clog2(Q_W);
    localparam logic [W-1:0] QNAN = W'(canon_qnan(EXP_W, MAN_W));

    state_t state, state_n;
    logic [W-1:0] op_q;
    logic [2:0] rm_q;
    logic [2*Q_W-1:0] rad;
    logic [R_W-1:0] rem, root;
    logic [NW-1:0] cnt;
    logic [EXP_W-1:0] rexp;

    logic sign;
    logic [EXP_W-1:0] ef;
    logic [MAN_W-1:0] fr;
    logic [CW-1:0] lz;
    assign {sign, ef, fr} = op_q;

    fsqrt_lzc #(.MAN_W(MAN_W)) u_lzc (.frac(fr), .count(lz));

    logic exp_max, is_zero, is_nan, special, sp_nv;
    logic [W-1:0] sp_res;
    logic [MAN_W:0] sig;
    logic [Q_W-1:0] sig_x;
    logic signed [EW-1:0] e_raw, e_adj;
    logic [EXP_W-1:0] rexp_n;

    always_comb begin
        exp_max = &ef;
        is_zero = ~|{ef, fr};
        is_nan  = exp_max & |fr;
        special = exp_max | is_zero | sign;
        sp_res  = (is_nan | (sign & ~is_zero)) ? QNAN : op_q;
        sp_nv   = is_nan ? ~fr[MAN_W-1] : sign & ~is_zero;
        sig     = |ef ? {1'b1, fr} : {1'b0, fr} << (lz + CW'(1));
        e_raw   = |ef ? EW'(ef) - EW'(BIAS) : -EW'(BIAS) - EW'(lz);
        // Odd exponents borrow a factor of two into the significand so e/2 is exact.
        e_adj   = e_raw - EW'(e_raw[0]);
        sig_x   = e_raw[0] ? {sig, 1'b0} : {1'b0, sig};
        rexp_n  = EXP_W'((e_adj >>> 1) + EW'(BIAS));
    end

    logic [R_W+1:0] rem_sh, trial;
    logic ge;

    always_comb begin
        rem_sh = {rem, rad[2*Q_W-1 -: 2]};
        trial  = {root, 2'b01};
        ge     = rem_sh >= trial;
    end

    logic g, st, lsb, inc;
    logic [MAN_W+1:0] mant;
    logic [W-1:0] rd_res;
    logic [4:0] rd_flags;

    always_comb begin
        g   = root[0];
        lsb = root[1];
        st  = |rem;
        inc = (rm_q == RM_RZ || rm_q == RM_RDN) ? 1'b0 :
              (rm_q == RM_RUP) ? g | st :
              (rm_q == RM_RMM) ? g : g & (st | lsb);
        mant   = {1'b0, root[Q_W-1:1]} + (MAN_W+2)'(inc);
        rd_res = {1'b0, rexp + EXP_W'(mant[MAN_W+1]), mant[MAN_W-1:0]};
        rd_flags[FLAG_NV] = 1'b0;
        rd_flags[FLAG_DZ] = 1'b0;
        rd_flags[FLAG_OF] = 1'b0;
        rd_flags[FLAG_UF] = 1'b0;
        rd_flags[FLAG_NX] = g | st;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? UNPACK : IDLE;
            UNPACK:  state_n = special ? DONE : ITER;
            ITER:    state_n = (cnt == NW'(Q_W - 1)) ? ROUND : ITER;
            ROUND:   state_n = DONE;
            DONE:    state_n = start ? UNPACK : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == UNPACK) || (state == ITER) || (state == ROUND);
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            rm_q   <= '0;
            rad    <= '0;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
            rexp   <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            if (start && (state == IDLE || state == DONE)) begin
                op_q <= op;
                rm_q <= (rm > RM_RMM) ? RM_RNE : rm;
            end
            if (state == UNPACK) begin
                if (special) begin
                    result <= sp_res;
                    flags  <= {sp_nv, 4'b0000};
                end
                rad  <= {sig_x, Q_W'(0)};
                rem  <= '0;
                root <= '0;
                cnt  <= '0;
                rexp <= rexp_n;
            end
            if (state == ITER) begin
                rad  <= rad << 2;
                rem  <= R_W'(ge ? rem_sh - trial : rem_sh);
                root <= {root[R_W-2:0], ge};
                cnt  <= cnt + 1'b1;
            end
            if (state == ROUND) begin
                result <= rd_res;
                flags  <= rd_flags;
            end
        end
    end

endmodule
